// File: rtl/vdas_cmd_pkg.sv
// Shared opcodes, FSM state type and instruction-length rule for the VDAS command decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vdas_cmd_pkg;

    localparam logic [2:0] OP_ACTIVATE   = 3'b000;
    localparam logic [2:0] OP_SETDIGITAL = 3'b001;
    localparam logic [2:0] OP_SETANALOG  = 3'b010;
    localparam logic [2:0] OP_DOUT_BULK  = 3'b011;
    localparam logic [2:0] OP_STATUS     = 3'b100;
    localparam logic [2:0] OP_CLEAR_ERR  = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        EXEC    = 3'd2,
        RESP0   = 3'd3,
        RESP1   = 3'd4
    } state_t;

    // Instruction length in bytes is a function of the opcode only.
    function automatic logic [1:0] op_len(input logic [2:0] op);
        return (op == OP_SETANALOG || op == OP_DOUT_BULK) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Idle-cycle counter that flags when a partial instruction has waited too long.
// Latency: expired is combinational, high on the TIMEOUT_CYC-th consecutive enabled cycle.
// Backpressure: none; clr has priority over en.
module cmd_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    // Count enabled cycles, saturating at TIMEOUT_CYC; any clear restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != CW'(TIMEOUT_CYC)) begin
            count <= count + CW'(1);
        end
    end

    // The cycle that would bring the count to TIMEOUT_CYC is the one that gives up.
    assign expired = en && !clr && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cmd_decoder.sv
// Pops 1/3-byte host instructions from the RX FIFO, executes them on the enable/GPIO/DAC registers, queues status replies.
// Latency: outputs update on the edge ending the cycle after the last byte is popped; aout_strobe follows for one cycle.
// Backpressure: pops only while RX non-empty in IDLE/COLLECT; replies stall indefinitely while tx_full.
module cmd_decoder
    import vdas_cmd_pkg::*;
#(
    parameter int N_MODS      = 5,
    parameter int N_DOUT      = 8,
    parameter int N_AOUT      = 2,
    parameter int AOUT_W      = 12,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_empty,
    output logic                     rx_pop,
    output logic [7:0]               tx_data,
    input  logic                     tx_full,
    output logic                     tx_push,
    output logic [N_MODS-1:0]        activemods,
    output logic [N_DOUT-1:0]        dout,
    output logic [N_AOUT*AOUT_W-1:0] aout,
    output logic [N_AOUT-1:0]        aout_strobe,
    output logic                     err
);

    state_t      state;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [7:0]  byte2;
    logic        got1;
    logic        armed;
    logic        to_en;
    logic        to_clr;
    logic        to_expired;
    logic [2:0]  op;
    logic [15:0] analog_val;
    logic [15:0] bulk_val;
    logic        mod_ok;
    logic        dig_ok;
    logic        ch_ok;

    assign op         = byte0[7:5];
    assign analog_val = {byte1, byte2};
    assign bulk_val   = {byte2, byte1};
    assign mod_ok     = int'(byte0[3:0]) < N_MODS;
    assign dig_ok     = int'(byte0[4:1]) < N_DOUT;
    assign ch_ok      = int'(byte0[4:0]) < N_AOUT;

    // armed holds pops off until the first clock after reset release, so nothing
    // is consumed while rst_n is low even though state already reads IDLE.
    assign rx_pop  = armed && !rx_empty && (state == IDLE || state == COLLECT);
    assign tx_push = (state == RESP0 || state == RESP1) && !tx_full;

    // Reply bytes: zero-extended module enables, then the error flag in the MSB.
    always_comb begin
        tx_data = 8'h00;
        if (state == RESP0) begin
            tx_data = 8'(activemods);
        end else if (state == RESP1) begin
            tx_data = {err, 7'b0};
        end
    end

    assign to_en  = (state == COLLECT) && rx_empty;
    assign to_clr = (state != COLLECT) || rx_pop;

    cmd_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // Instruction sequencing: gather bytes, run one EXEC cycle, then emit replies if any.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            byte0 <= 8'h00;
            byte1 <= 8'h00;
            byte2 <= 8'h00;
            got1  <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (rx_pop) begin
                        byte0 <= rx_data;
                        got1  <= 1'b0;
                        state <= (op_len(rx_data[7:5]) == 2'd1) ? EXEC : COLLECT;
                    end
                end
                COLLECT: begin
                    if (rx_pop) begin
                        if (!got1) begin
                            byte1 <= rx_data;
                            got1  <= 1'b1;
                        end else begin
                            byte2 <= rx_data;
                            state <= EXEC;
                        end
                    end else if (to_expired) begin
                        state <= IDLE;
                    end
                end
                EXEC:    state <= (op == OP_STATUS) ? RESP0 : IDLE;
                RESP0:   if (!tx_full) state <= RESP1;
                RESP1:   if (!tx_full) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register updates: exactly one instruction applied per EXEC; timeout also raises err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            activemods  <= '0;
            dout        <= '0;
            aout        <= '0;
            aout_strobe <= '0;
            err         <= 1'b0;
        end else begin
            aout_strobe <= '0;
            if (state == COLLECT && !rx_pop && to_expired) begin
                err <= 1'b1;
            end
            if (state == EXEC) begin
                case (op)
                    OP_ACTIVATE: begin
                        if (mod_ok) begin
                            for (int i = 0; i < N_MODS; i++) begin
                                if (byte0[3:0] == i[3:0]) activemods[i] <= byte0[4];
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_SETDIGITAL: begin
                        if (dig_ok) begin
                            for (int i = 0; i < N_DOUT; i++) begin
                                if (byte0[4:1] == i[3:0]) dout[i] <= byte0[0];
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_SETANALOG: begin
                        if (ch_ok) begin
                            for (int i = 0; i < N_AOUT; i++) begin
                                if (byte0[4:0] == i[4:0]) begin
                                    aout[i*AOUT_W +: AOUT_W] <= analog_val[AOUT_W-1:0];
                                    aout_strobe[i]           <= 1'b1;
                                end
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_DOUT_BULK: dout <= bulk_val[N_DOUT-1:0];
                    OP_STATUS:    begin end
                    OP_CLEAR_ERR: err <= 1'b0;
                    default:      err <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: doc/cmd_decoder.md
# cmd_decoder

Parametrised command decoder for the VDAS FPGA. It pops variable-length instruction bytes from the host receive FIFO and decodes them, then updates the module-enable, digital-output and analog-output registers. Status responses go into a transmit FIFO. It sits between the UART/USB byte queues and the ADC/DAC/GPIO blocks. Over the first-generation controller it adds channel/width parameters, deactivate, bulk digital write, status readback, error flagging and a partial-instruction timeout.

## Interface
- N_MODS, 5, number of module-enable bits (1..8)
- N_DOUT, 8, digital output count (1..16)
- N_AOUT, 2, analog output channels (1..32)
- AOUT_W, 12, analog code width (1..16)
- TIMEOUT_CYC, 1000000, idle cycles before a partial instruction is discarded (≥2)
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- rx_data  in  8  head byte of RX FIFO (show-ahead, valid when !rx_empty)
- rx_empty  in  1  RX FIFO empty
- rx_pop  out  1  consume head byte this cycle
- tx_data  out  8  response byte
- tx_full  in  1  TX FIFO full
- tx_push  out  1  write tx_data this cycle
- activemods  out  N_MODS  module enables
- dout  out  N_DOUT  digital outputs
- aout  out  N_AOUT*AOUT_W  analog codes, channel k at [k*AOUT_W +: AOUT_W]
- aout_strobe  out  N_AOUT  one-cycle pulse per channel updated
- err  out  1  sticky error flag

## Operation
- Byte0 = {op[2:0], arg[4:0]}. Total length is decided from op alone.
- 000 ACTIVATE (1 byte): idx=arg[3:0], activemods[idx] <= arg[4].
- 001 SETDIGITAL (1 byte): idx=arg[4:1], dout[idx] <= arg[0].
- 010 SETANALOG (3 bytes): ch=arg[4:0], value={byte1,byte2}; aout[ch] <= value[AOUT_W-1:0]; aout_strobe[ch] pulses.
- 011 DOUT_BULK (3 bytes): dout <= {byte2,byte1}[N_DOUT-1:0].
- 100 STATUS (1 byte): push two bytes, zero-extended activemods, then {err, 7'b0}.
- 111 CLEAR_ERR (1 byte): err <= 0.
- 101 and 110 are illegal. They are 1 byte, set err and produce no other effect.
- An index or channel ≥ N_MODS/N_DOUT/N_AOUT ignores the operation and sets err.
- States are IDLE, COLLECT, EXEC, RESP0, RESP1.
  - IDLE: on !rx_empty, pop byte0. A 1-byte op goes to EXEC, otherwise to COLLECT.
  - COLLECT: pop each available byte. After the last byte, go to EXEC.
  - EXEC: apply the operation. STATUS goes to RESP0, everything else to IDLE.
  - RESP0: push first byte when !tx_full, then go to RESP1.
  - RESP1: push second byte when !tx_full, then go to IDLE.
- Timeout: a counter runs in COLLECT while rx_empty and clears on each pop. At TIMEOUT_CYC it discards the partial instruction, sets err and returns to IDLE.
- Reset values: activemods=0, dout=0, aout=0, aout_strobe=0, err=0, rx_pop=0, tx_push=0, tx_data=0, state=IDLE, counter=0.

## Timing
- rx_pop is combinational from state and !rx_empty. It is high only in IDLE/COLLECT with !rx_empty, never in EXEC/RESP. At most one byte per cycle; rx_data is sampled on the same edge.
- A 1-byte op popped in cycle T puts the FSM in EXEC in T+1. The outputs change at the end of T+1.
- A 3-byte op with bytes back-to-back in T..T+2 executes in T+3.
- aout_strobe is high for exactly the one cycle after the EXEC edge. It is aligned with the new aout value.
- tx_push is never asserted while tx_full. The FSM stalls in RESP0/RESP1 indefinitely; no timeout applies there.
- Gaps in rx between bytes are tolerated up to TIMEOUT_CYC-1 cycles.
- When an error and CLEAR_ERR occur in the same EXEC, there is no conflict because exactly one op is executed per EXEC.
- Reset asserted mid-instruction drops all partial state immediately. No pop or push may occur during reset.

## Structure
- Package vdas_cmd_pkg contains:
  - opcode localparams OP_ACTIVATE..OP_CLEAR_ERR
  - the state enum
  - function op_len(op) returning 1 or 3
- Sub-module cmd_timeout_ctr (parameter TIMEOUT_CYC; inputs clr, en; output expired), counter width $clog2(TIMEOUT_CYC+1).
- The decode/execute FSM and the output registers live in cmd_decoder.

## Test plan
- Reset, then push 0x13 (ACTIVATE idx3 set) → activemods=5'b01000 two cycles after pop. Then 0x03 → activemods=0.
- Push 0x2B (SETDIGITAL idx5 val1) → dout=8'h20. Then 0x7F,0x34,0x12 (DOUT_BULK) → dout=8'h34.
- Push 0x41,0xAB,0xCD (SETANALOG ch1) → aout[1]=12'hBCD and aout_strobe=2'b10 for one cycle; aout[0] stays 0.
- Push 0x5F,0x00,0x01 (channel 31 ≥ N_AOUT) → aout unchanged, err=1. Then 0x80 with tx_full held 10 cycles → tx_push only after release; bytes 0x00 then 0x80. Then 0xE0 → err=0.
- Push 0x40 only with TIMEOUT_CYC=16 → after 16 empty cycles, err=1 and state IDLE. Next 0x11 executes normally (activemods[1]=1).
- Assert rst_n low during COLLECT of a 3-byte op → all outputs return to reset values. After release the next byte is decoded as byte0.
